apbmaster: RTL and testbench
============================

// Module: apbmaster
// PURPOSE
//  APB initiator for the systolic-array register interface (control, operand A/B, flags, scratchpad).
//  Turns one request into one APB transfer: SETUP phase, then ACCESS phase until pready_i, then returns the response.
//  Sits between the host/test sequencer and apbslave, so register access needs no hand-driven APB pins.
//  ACCESS is bounded by a wait-state timeout, so a hung or busy slave cannot stall the sequencer.
// PARAMETERS
//  DW       8      data element width; sets strobe granularity
//  BW       32     APB data bus width
//  ADDR_W   16     APB address width
//  MAX_DIM  BW/DW  strobe width (one bit per DW element)
//  TIMEOUT  16     max ACCESS cycles without pready_i before abort; 0 = timeout disabled
// PORTS
//  clk_i          in   1        clock
//  reset_ni       in   1        reset, synchronous, active-low
//  req_valid_i    in   1        request present
//  req_ready_o    out  1        request accepted when valid&&ready
//  req_write_i    in   1        1=write, 0=read
//  req_addr_i     in   ADDR_W   target address
//  req_wdata_i    in   BW       write data
//  req_strb_i     in   MAX_DIM  write strobes
//  rsp_valid_o    out  1        response present
//  rsp_ready_i    in   1        response consumed when valid&&ready
//  rsp_rdata_o    out  BW       read data (0 for writes / timeouts)
//  rsp_err_o      out  1        pslverr_i seen, or timeout
//  rsp_timeout_o  out  1        transfer aborted by timeout
//  psel_o         out  1        APB select
//  penable_o      out  1        APB enable
//  pwrite_o       out  1        APB direction
//  paddr_o        out  ADDR_W   APB address
//  pwdata_o       out  BW       APB write data
//  pstrb_o        out  MAX_DIM  APB strobes
//  prdata_i       in   BW       APB read data
//  pready_i       in   1        APB ready
//  pslverr_i      in   1        APB slave error
//  busy_o         out  1        high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready_o=1; state=IDLE; wait counter=0. Outputs are registered except req_ready_o.
//  req_ready_o = (state==IDLE) and not in reset.
//  IDLE:
//   - On req_valid_i&&req_ready_o: capture write/addr/wdata/strb, then go to SETUP.
//   - Read requests capture pwdata=0 and pstrb=0.
//  SETUP (1 cycle):
//   - psel_o=1, penable_o=0; paddr/pwrite/pwdata/pstrb driven from the captured request.
//   - Go to ACCESS.
//  ACCESS:
//   - psel_o=1, penable_o=1; all bus fields held stable.
//   - pready_i=1: rsp_rdata_o = read ? prdata_i : 0; rsp_err_o=pslverr_i; rsp_timeout_o=0;
//     drop psel/penable; go to RESP.
//   - pready_i=0: increment wait counter.
//   - If TIMEOUT!=0 and the counter reaches TIMEOUT (TIMEOUT ACCESS cycles with no pready):
//     rsp_err_o=1, rsp_timeout_o=1, rdata=0; drop psel/penable; go to RESP.
//   - If pready_i rises in the same cycle the limit is reached, pready wins (normal completion).
//  RESP:
//   - rsp_valid_o=1; rsp_* held stable until rsp_ready_i=1.
//   - On consume: rsp_valid_o=0, counter=0, go to IDLE.
//   - No new request is accepted until IDLE.
//  Latency: accept at edge N -> psel at N+1 -> penable at N+2 -> with zero wait states, rsp_valid at N+3.
//  Back-to-back requests: at least 1 idle bus cycle between transfers (psel_o=0 in IDLE).
//  Idle bus: paddr/pwrite/pwdata/pstrb hold their last values; psel_o=penable_o=0.
//  Reset mid-transfer: next edge forces the reset state; an in-flight transfer is dropped and no response is issued.
// TESTING
//  1 Write 0x0000 <- 0x00000001, strb 0xF; slave pready on the 2nd ACCESS cycle
//    -> SETUP 1 cycle, penable 2 cycles, rsp_valid with err=0, rdata=0.
//  2 Read 0x0004; slave pready on the 1st ACCESS cycle with prdata 0xDEADBEEF
//    -> rsp_valid 3 cycles after accept, rdata=0xDEADBEEF.
//  3 Write while the slave is busy: pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0.
//  4 pready held 0, TIMEOUT=16 -> psel drops after exactly 16 ACCESS cycles; err=1, timeout=1, rdata=0.
//  5 rsp_ready_i low for 5 cycles while req_valid_i=1
//    -> rsp fields stable, req_ready_o=0, psel stays 0; next request accepted only after consume.
//  6 reset_ni low during ACCESS -> next edge psel/penable/rsp_valid/busy=0; after release req_ready_o=1.

Source files
------------

// File: rtl/apbmaster.sv
// APB initiator: one request becomes one APB transfer (SETUP, then ACCESS until pready_i or a
// wait-state timeout), and the outcome is returned on a valid/ready response channel.
module apbmaster #(
    parameter int DW      = 8,
    parameter int BW      = 32,
    parameter int ADDR_W  = 16,
    parameter int MAX_DIM = BW / DW,
    parameter int TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_write_i,
    input  logic [ADDR_W-1:0]  req_addr_i,
    input  logic [BW-1:0]      req_wdata_i,
    input  logic [MAX_DIM-1:0] req_strb_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [BW-1:0]      rsp_rdata_o,
    output logic               rsp_err_o,
    output logic               rsp_timeout_o,
    output logic               psel_o,
    output logic               penable_o,
    output logic               pwrite_o,
    output logic [ADDR_W-1:0]  paddr_o,
    output logic [BW-1:0]      pwdata_o,
    output logic [MAX_DIM-1:0] pstrb_o,
    input  logic [BW-1:0]      prdata_i,
    input  logic               pready_i,
    input  logic               pslverr_i,
    output logic               busy_o
);

    localparam int CW = (TIMEOUT > 32'sd1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 32'sd0) ? (TIMEOUT - 32'sd1) : 32'sd0);
    localparam bit TMO_EN = (TIMEOUT > 32'sd0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, next_state;

    logic               cap_write, cap_write_nxt;
    logic [ADDR_W-1:0]  cap_addr, cap_addr_nxt;
    logic [BW-1:0]      cap_wdata, cap_wdata_nxt;
    logic [MAX_DIM-1:0] cap_strb, cap_strb_nxt;
    logic [CW-1:0]      wait_cnt, wait_cnt_nxt;

    logic               psel_nxt, penable_nxt, pwrite_nxt, busy_nxt;
    logic [ADDR_W-1:0]  paddr_nxt;
    logic [BW-1:0]      pwdata_nxt;
    logic [MAX_DIM-1:0] pstrb_nxt;
    logic               rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
    logic [BW-1:0]      rsp_rdata_nxt;

    logic accept, access_live, limit_hit, done_ok, done_tmo, finish;

    assign req_ready_o = (state == IDLE) && reset_ni;
    assign accept      = req_valid_i && req_ready_o;
    // The bus lags the state by one register, so a real ACCESS cycle is one with penable_o high.
    assign access_live = (state == ACCESS) && penable_o;
    assign limit_hit   = TMO_EN && (wait_cnt == LIMIT);
    assign done_ok     = access_live && pready_i;
    assign done_tmo    = access_live && !pready_i && limit_hit;
    assign finish      = done_ok || done_tmo;

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? SETUP : IDLE;
            SETUP:   next_state = ACCESS;
            ACCESS:  next_state = finish ? RESP : ACCESS;
            RESP:    next_state = rsp_ready_i ? IDLE : RESP;
            default: next_state = IDLE;
        endcase
    end

    // Next values for the registered outputs, the captured request and the wait counter
    always_comb begin
        busy_nxt    = (next_state != IDLE);
        psel_nxt    = (state == SETUP) || ((state == ACCESS) && !finish);
        penable_nxt = (state == ACCESS) && !finish;

        if (accept) begin
            cap_write_nxt = req_write_i;
            cap_addr_nxt  = req_addr_i;
            cap_wdata_nxt = req_write_i ? req_wdata_i : {BW{1'b0}};
            cap_strb_nxt  = req_write_i ? req_strb_i : {MAX_DIM{1'b0}};
        end else begin
            cap_write_nxt = cap_write;
            cap_addr_nxt  = cap_addr;
            cap_wdata_nxt = cap_wdata;
            cap_strb_nxt  = cap_strb;
        end

        if (state == SETUP) begin
            pwrite_nxt = cap_write;
            paddr_nxt  = cap_addr;
            pwdata_nxt = cap_wdata;
            pstrb_nxt  = cap_strb;
        end else begin
            pwrite_nxt = pwrite_o;
            paddr_nxt  = paddr_o;
            pwdata_nxt = pwdata_o;
            pstrb_nxt  = pstrb_o;
        end

        rsp_valid_nxt = ((state == ACCESS) && finish) || ((state == RESP) && !rsp_ready_i);
        if (done_ok) begin
            rsp_rdata_nxt   = cap_write ? {BW{1'b0}} : prdata_i;
            rsp_err_nxt     = pslverr_i;
            rsp_timeout_nxt = 1'b0;
        end else if (done_tmo) begin
            rsp_rdata_nxt   = {BW{1'b0}};
            rsp_err_nxt     = 1'b1;
            rsp_timeout_nxt = 1'b1;
        end else begin
            rsp_rdata_nxt   = rsp_rdata_o;
            rsp_err_nxt     = rsp_err_o;
            rsp_timeout_nxt = rsp_timeout_o;
        end

        if ((state == RESP) && rsp_ready_i) begin
            wait_cnt_nxt = {CW{1'b0}};
        end else if (access_live && !pready_i && !limit_hit) begin
            wait_cnt_nxt = wait_cnt + CW'(1'b1);
        end else begin
            wait_cnt_nxt = wait_cnt;
        end
    end

    // Output, capture and counter registers
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            busy_o        <= 1'b0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= {ADDR_W{1'b0}};
            pwdata_o      <= {BW{1'b0}};
            pstrb_o       <= {MAX_DIM{1'b0}};
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= {BW{1'b0}};
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            cap_write     <= 1'b0;
            cap_addr      <= {ADDR_W{1'b0}};
            cap_wdata     <= {BW{1'b0}};
            cap_strb      <= {MAX_DIM{1'b0}};
            wait_cnt      <= {CW{1'b0}};
        end else begin
            busy_o        <= busy_nxt;
            psel_o        <= psel_nxt;
            penable_o     <= penable_nxt;
            pwrite_o      <= pwrite_nxt;
            paddr_o       <= paddr_nxt;
            pwdata_o      <= pwdata_nxt;
            pstrb_o       <= pstrb_nxt;
            rsp_valid_o   <= rsp_valid_nxt;
            rsp_rdata_o   <= rsp_rdata_nxt;
            rsp_err_o     <= rsp_err_nxt;
            rsp_timeout_o <= rsp_timeout_nxt;
            cap_write     <= cap_write_nxt;
            cap_addr      <= cap_addr_nxt;
            cap_wdata     <= cap_wdata_nxt;
            cap_strb      <= cap_strb_nxt;
            wait_cnt      <= wait_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_apbmaster.sv
// Directed bench for apbmaster: a transaction-window model predicts every output each cycle,
// and the test sequence pins that model with hand-computed latencies and data.
module tb_apbmaster;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_ni, req_valid, req_write, rsp_ready, pready, pslverr;
    logic [15:0] req_addr;
    logic [31:0] req_wdata, prdata;
    logic [3:0]  req_strb;
    logic        req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o;
    logic        psel_o, penable_o, pwrite_o, busy_o;
    logic [31:0] rsp_rdata_o, pwdata_o;
    logic [15:0] paddr_o;
    logic [3:0]  pstrb_o;

    always #5 clk = ~clk;

    apbmaster #(.DW(8), .BW(32), .ADDR_W(16), .MAX_DIM(4), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .prdata_i(prdata), .pready_i(pready),
        .pslverr_i(pslverr), .busy_o(busy_o)
    );

    int nvec = 0;
    int nerr = 0;

    // Slave behaviour for the current transfer: pready on ACCESS cycle cfg_w+1 (never if negative)
    int          cfg_w = 0;
    logic        cfg_err = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Slave: drives pready/pslverr/prdata away from the sampling edge, junk when not ready
    initial begin
        int acc = 0;
        forever begin
            @(negedge clk);
            if (penable_o) begin
                pready  = (cfg_w >= 0) && (acc == cfg_w);
                pslverr = pready ? cfg_err : 1'b1;
                prdata  = pready ? cfg_rdata : 32'hA5A5_5A5A;
                acc++;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = 32'h0BAD_F00D;
                acc     = 0;
            end
        end
    end

    // Model: each accepted request occupies fixed windows relative to its accept edge
    initial begin
        int          cyc = 0;
        int          n_acc = 0;
        int          n_a = 0;
        bit          inflight = 1'b0;
        bit          rst_seen;
        bit          tmo;
        logic [31:0] e_rdata = 32'h0;
        logic        e_err = 1'b0, e_tmo = 1'b0;
        logic [15:0] cur_addr = 16'h0, prev_addr = 16'h0;
        logic        cur_write = 1'b0, prev_write = 1'b0;
        logic [31:0] cur_wdata = 32'h0, prev_wdata = 32'h0;
        logic [3:0]  cur_strb = 4'h0, prev_strb = 4'h0;
        bit          use_prev, e_psel, e_pen, e_rv;
        forever begin
            @(posedge clk);
            cyc++;
            rst_seen = !reset_ni;
            if (!reset_ni) begin
                inflight = 1'b0;
                cur_addr = 16'h0; cur_write = 1'b0; cur_wdata = 32'h0; cur_strb = 4'h0;
                prev_addr = 16'h0; prev_write = 1'b0; prev_wdata = 32'h0; prev_strb = 4'h0;
            end else if (!inflight && req_valid) begin
                inflight = 1'b1;
                n_acc = cyc;
                tmo = (cfg_w < 0) || (cfg_w + 1 > TIMEOUT);
                n_a = tmo ? TIMEOUT : cfg_w + 1;
                e_tmo = tmo;
                e_err = tmo || cfg_err;
                e_rdata = (tmo || req_write) ? 32'h0 : cfg_rdata;
                prev_addr = cur_addr; prev_write = cur_write;
                prev_wdata = cur_wdata; prev_strb = cur_strb;
                cur_addr = req_addr; cur_write = req_write;
                cur_wdata = req_write ? req_wdata : 32'h0;
                cur_strb = req_write ? req_strb : 4'h0;
            end else if (inflight && (cyc - 1 >= n_acc + 2 + n_a) && rsp_ready) begin
                inflight = 1'b0;
            end
            #1;
            use_prev = inflight && (cyc == n_acc);
            e_psel = inflight && (cyc >= n_acc + 1) && (cyc <= n_acc + 1 + n_a);
            e_pen  = inflight && (cyc >= n_acc + 2) && (cyc <= n_acc + 1 + n_a);
            e_rv   = inflight && (cyc >= n_acc + 2 + n_a);
            cmp("busy", 32'(busy_o), 32'(inflight));
            cmp("req_ready", 32'(req_ready_o), 32'(!inflight && reset_ni));
            cmp("psel", 32'(psel_o), 32'(e_psel));
            cmp("penable", 32'(penable_o), 32'(e_pen));
            cmp("rsp_valid", 32'(rsp_valid_o), 32'(e_rv));
            cmp("paddr", 32'(paddr_o), 32'(use_prev ? prev_addr : cur_addr));
            cmp("pwrite", 32'(pwrite_o), 32'(use_prev ? prev_write : cur_write));
            cmp("pwdata", pwdata_o, use_prev ? prev_wdata : cur_wdata);
            cmp("pstrb", 32'(pstrb_o), 32'(use_prev ? prev_strb : cur_strb));
            if (e_rv) begin
                cmp("rsp_rdata", rsp_rdata_o, e_rdata);
                cmp("rsp_err", 32'(rsp_err_o), 32'(e_err));
                cmp("rsp_timeout", 32'(rsp_timeout_o), 32'(e_tmo));
            end
            if (rst_seen) begin
                cmp("rst_rdata", rsp_rdata_o, 32'h0);
                cmp("rst_err", 32'(rsp_err_o), 32'h0);
                cmp("rst_timeout", 32'(rsp_timeout_o), 32'h0);
            end
        end
    end

    task automatic start_req(input logic wr, input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int w, input logic e, input logic [31:0] rd);
        req_write = wr; req_addr = a; req_wdata = d; req_strb = s;
        cfg_w = w; cfg_err = e; cfg_rdata = rd;
        req_valid = 1'b1;
    endtask

    // Returns at the negedge of the accept cycle with req_valid dropped
    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) cmp("accept_wait", 32'h0, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // lat counts cycles from accept to rsp_valid, pen counts penable-high cycles seen
    task automatic wait_rsp(output int lat, output int pen);
        bit ok = 1'b0;
        lat = 0;
        pen = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid_o) begin
                ok = 1'b1;
                break;
            end
            if (penable_o) pen++;
            @(negedge clk);
            lat++;
        end
        if (!ok) cmp("rsp_wait", 32'h0, 32'h1);
    endtask

    task automatic consume(input int hold);
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat, pen;
        reset_ni = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0;
        req_wdata = 32'h0; req_strb = 4'h0; rsp_ready = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        repeat (3) @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
        cmp("t0_req_ready", 32'(req_ready_o), 32'h1);
        cmp("t0_busy", 32'(busy_o), 32'h0);

        // 1: write, pready on 2nd ACCESS cycle
        start_req(1'b1, 16'h0000, 32'h0000_0001, 4'hF, 1, 1'b0, 32'h0);
        wait_accept();
        wait_rsp(lat, pen);
        cmp("t1_penable_cycles", 32'(pen), 32'd2);
        cmp("t1_latency", 32'(lat), 32'd4);
        cmp("t1_err", 32'(rsp_err_o), 32'h0);
        cmp("t1_rdata", rsp_rdata_o, 32'h0);
        consume(0);

        // 2: read, zero wait states
        start_req(1'b0, 16'h0004, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'hDEAD_BEEF);
        wait_accept();
        wait_rsp(lat, pen);
        cmp("t2_latency", 32'(lat), 32'd3);
        cmp("t2_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
        consume(1);

        // 3: write with slave error
        start_req(1'b1, 16'h0008, 32'h1234_5678, 4'h3, 0, 1'b1, 32'h0);
        wait_accept();
        wait_rsp(lat, pen);
        cmp("t3_err", 32'(rsp_err_o), 32'h1);
        cmp("t3_timeout", 32'(rsp_timeout_o), 32'h0);
        consume(0);

        // 4: slave never ready -> timeout after 16 ACCESS cycles
        start_req(1'b0, 16'h000C, 32'h0, 4'h0, -1, 1'b0, 32'h7777_7777);
        wait_accept();
        wait_rsp(lat, pen);
        cmp("t4_penable_cycles", 32'(pen), 32'd16);
        cmp("t4_err", 32'(rsp_err_o), 32'h1);
        cmp("t4_timeout", 32'(rsp_timeout_o), 32'h1);
        cmp("t4_rdata", rsp_rdata_o, 32'h0);
        consume(0);

        // boundary: pready on exactly the 16th cycle wins; on the 17th it is too late
        start_req(1'b0, 16'h0010, 32'h0, 4'h0, 15, 1'b0, 32'h1357_9BDF);
        wait_accept();
        wait_rsp(lat, pen);
        cmp("tb15_timeout", 32'(rsp_timeout_o), 32'h0);
        cmp("tb15_rdata", rsp_rdata_o, 32'h1357_9BDF);
        consume(0);
        start_req(1'b0, 16'h0014, 32'h0, 4'h0, 16, 1'b0, 32'h2468_ACE0);
        wait_accept();
        wait_rsp(lat, pen);
        cmp("tb16_penable_cycles", 32'(pen), 32'd16);
        cmp("tb16_timeout", 32'(rsp_timeout_o), 32'h1);
        consume(0);

        // 5: response held 5 cycles while the next request waits
        start_req(1'b1, 16'h0018, 32'hCAFE_F00D, 4'h3, 0, 1'b0, 32'h0);
        wait_accept();
        wait_rsp(lat, pen);
        start_req(1'b0, 16'h001C, 32'h0, 4'h0, 0, 1'b0, 32'h5555_AAAA);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp("t5_req_ready", 32'(req_ready_o), 32'h0);
            cmp("t5_psel", 32'(psel_o), 32'h0);
            cmp("t5_rsp_valid", 32'(rsp_valid_o), 32'h1);
        end
        consume(0);
        wait_accept();
        wait_rsp(lat, pen);
        cmp("t5_rdata2", rsp_rdata_o, 32'h5555_AAAA);
        consume(0);

        // 6: reset during ACCESS drops the transfer
        start_req(1'b0, 16'h0020, 32'h0, 4'h0, -1, 1'b0, 32'h0);
        wait_accept();
        repeat (4) @(negedge clk);
        reset_ni = 1'b0;
        @(negedge clk);
        cmp("t6_psel", 32'(psel_o), 32'h0);
        cmp("t6_penable", 32'(penable_o), 32'h0);
        cmp("t6_rsp_valid", 32'(rsp_valid_o), 32'h0);
        cmp("t6_busy", 32'(busy_o), 32'h0);
        reset_ni = 1'b1;
        @(negedge clk);
        cmp("t6_req_ready", 32'(req_ready_o), 32'h1);

        // recovery after reset: partial-strobe write then read
        start_req(1'b1, 16'h0030, 32'h0F0F_0F0F, 4'h5, 2, 1'b0, 32'h0);
        wait_accept();
        wait_rsp(lat, pen);
        cmp("t7_penable_cycles", 32'(pen), 32'd3);
        consume(2);
        start_req(1'b0, 16'h0034, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, 32'h8000_0001);
        wait_accept();
        wait_rsp(lat, pen);
        cmp("t7_rdata", rsp_rdata_o, 32'h8000_0001);
        consume(0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
